// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage: format classification, sign-extended immediate and pc+imm target,
// behind a valid/ready handshake with a 2-entry (output + skid) buffer. Optional macro: IMM_ZICSR_EN.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_pc
);

  typedef enum logic [2:0] {
    FMT_R   = 3'b000,
    FMT_I   = 3'b001,
    FMT_S   = 3'b010,
    FMT_B   = 3'b011,
    FMT_U   = 3'b100,
    FMT_J   = 3'b101,
    FMT_ILL = 3'b111
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            ill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t      dec;
  entry_t      out_q;
  entry_t      skid_q;
  logic        skid_valid;
  logic [31:0] imm32;
  logic        in_xfer;

  assign in_xfer = in_valid && in_ready;

  // Every listed opcode ends in 2'b11, so instr[1:0] != 2'b11 falls into the default (illegal) arm.
  always_comb begin
    dec   = '0;
    imm32 = '0;
    unique case (in_instr[6:0])
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b0110011: dec.fmt = FMT_R;
      default:    dec.fmt = FMT_ILL;
    endcase
    dec.imm = XLEN'($signed(imm32));
`ifdef IMM_ZICSR_EN
    if (in_instr[6:0] == 7'b1110011 && in_instr[14]) begin
      dec.imm = XLEN'(in_instr[19:15]);
    end
`endif
    dec.ill    = (dec.fmt == FMT_ILL);
    dec.pc     = in_pc;
    dec.target = in_pc + dec.imm;
  end

  // in_ready tracks !skid_valid, so no input can be accepted while the skid entry is occupied.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (!out_valid || out_ready) begin
      in_ready <= 1'b1;
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_xfer;
        if (in_xfer) out_q <= dec;
      end
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

  assign out_imm     = out_q.imm;
  assign out_fmt     = FMT_W'(out_q.fmt);
  assign out_illegal = out_q.ill;
  assign out_target  = out_q.target;
  assign out_pc      = out_q.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: a 32-bit and a 64-bit instance, directed vectors with
// hand-computed expectations, monitors compare on every presented output.
module tb_imm_decode_stage;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
    logic [63:0] target;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        q32[$];
  exp_t        q64[$];

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_in_pc, a_out_imm, a_out_target, a_out_pc;
  logic [2:0]  a_out_fmt;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr;
  logic [63:0] b_in_pc, b_out_imm, b_out_target, b_out_pc;
  logic [2:0]  b_out_fmt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  imm_decode_stage #(.XLEN(32), .FMT_W(3)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal), .out_target(a_out_target), .out_pc(a_out_pc)
  );

  imm_decode_stage #(.XLEN(64), .FMT_W(3)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_illegal(b_out_illegal), .out_target(b_out_target), .out_pc(b_out_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops on a transfer; while stalled it checks the held values against the same queue head.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (reset_n === 1'b1 && a_out_valid === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out32: got imm %h pc %h expected no output", a_out_imm, a_out_pc);
      end else begin
        e = q32[0];
        chk("imm32", 64'(a_out_imm), e.imm);
        chk("fmt32", 64'(a_out_fmt), 64'(e.fmt));
        chk("ill32", 64'(a_out_illegal), 64'(e.ill));
        chk("pc32", 64'(a_out_pc), e.pc);
        chk("target32", 64'(a_out_target), e.target);
        if (a_out_ready) void'(q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (reset_n === 1'b1 && b_out_valid === 1'b1) begin
      if (q64.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out64: got imm %h pc %h expected no output", b_out_imm, b_out_pc);
      end else begin
        e = q64[0];
        chk("imm64", b_out_imm, e.imm);
        chk("fmt64", 64'(b_out_fmt), 64'(e.fmt));
        chk("ill64", 64'(b_out_illegal), 64'(e.ill));
        chk("pc64", b_out_pc, e.pc);
        chk("target64", b_out_target, e.target);
        if (b_out_ready) void'(q64.pop_front());
      end
    end
  end

  task automatic send(input bit w64, input logic [31:0] instr, input logic [63:0] pc,
                      input logic [63:0] imm, input logic [63:0] target, input logic [2:0] fmt);
    exp_t e;
    bit   got = 0;
    e.imm = imm; e.fmt = fmt; e.ill = (fmt == 3'b111); e.pc = pc; e.target = target;
    if (w64) begin b_in_valid = 1'b1; b_in_instr = instr; b_in_pc = pc; end
    else begin a_in_valid = 1'b1; a_in_instr = instr; a_in_pc = pc[31:0]; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((w64 ? b_in_ready : a_in_ready) === 1'b1) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready 0 for 50 cycles expected 1 (instr %h)", instr);
    end else begin
      @(posedge clk);
      if (w64) q64.push_back(e); else q32.push_back(e);
    end
    #1;
    if (w64) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q32.size() == 0 && q64.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0;
    reset_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(a_out_valid), 0);
    chk("rst_imm", 64'(a_out_imm), 0);
    chk("rst_fmt", 64'(a_out_fmt), 0);
    chk("rst_ill", 64'(a_out_illegal), 0);
    chk("rst_target", 64'(a_out_target), 0);
    chk("rst_pc", 64'(a_out_pc), 0);
    chk("rst_in_ready", 64'(a_in_ready), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(a_in_ready), 1);

    // Back-to-back stream with out_ready=1: one accept per cycle.
    c0 = cyc;
    send(0, 32'hFFF00093, 64'h0,    64'hFFFFFFFF, 64'hFFFFFFFF, 3'b001);
    chk("latency1", 64'(a_out_valid), 1);
    send(0, 32'hFFDFF0EF, 64'h100,  64'hFFFFFFFC, 64'h000000FC, 3'b101);
    send(0, 32'hFE000EE3, 64'h40,   64'hFFFFFFFC, 64'h0000003C, 3'b011);
    send(0, 32'h002081B3, 64'h80,   64'h0,        64'h80,       3'b000);
    send(0, 32'h8000A083, 64'h10,   64'hFFFFF800, 64'hFFFFF810, 3'b001);
    send(0, 32'hFFFFF297, 64'h1000, 64'hFFFFF000, 64'h0,        3'b100);
    send(0, 32'hFFF00091, 64'h20,   64'h0,        64'h20,       3'b111);
`ifdef IMM_ZICSR_EN
    send(0, 32'h3002D0F3, 64'h0,    64'h5,        64'h5,        3'b001);
`else
    send(0, 32'h3002D0F3, 64'h0,    64'h300,      64'h300,      3'b001);
`endif
    chk("throughput", 64'(cyc - c0), 64'd8);
    drain();

    // Backpressure: second accept lands in the skid, third waits.
    a_out_ready = 0;
    send(0, 32'h123452B7, 64'h200, 64'h12345000, 64'h12345200, 3'b100);
    send(0, 32'h0020A423, 64'h204, 64'h8,        64'h20C,      3'b010);
    chk("in_ready_full", 64'(a_in_ready), 0);
    fork
      send(0, 32'h00000000, 64'h208, 64'h0, 64'h208, 3'b111);
      begin repeat (3) @(posedge clk); #1; a_out_ready = 1; end
    join
    drain();

    // Flush with both entries full; the presented input must never appear.
    a_out_ready = 0;
    send(0, 32'hFFF00093, 64'h300, 64'hFFFFFFFF, 64'h2FF, 3'b001);
    send(0, 32'h0020A423, 64'h304, 64'h8,        64'h30C, 3'b010);
    a_flush = 1; a_in_valid = 1; a_in_instr = 32'h123452B7; a_in_pc = 32'h308;
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0; q32.delete();
    chk("flush_valid", 64'(a_out_valid), 0);
    chk("flush_in_ready", 64'(a_in_ready), 1);

    // Flush with skid empty: the input accepted in the flush cycle is discarded.
    send(0, 32'h002081B3, 64'h400, 64'h0, 64'h400, 3'b000);
    a_flush = 1; a_in_valid = 1; a_in_instr = 32'hFFDFF0EF; a_in_pc = 32'h404;
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0; q32.delete();
    chk("flush2_valid", 64'(a_out_valid), 0);
    a_out_ready = 1;
    repeat (3) @(posedge clk); #1;
    chk("flush2_no_ghost", 64'(a_out_valid), 0);
    send(0, 32'hFFDFF0EF, 64'h500, 64'hFFFFFFFC, 64'h4FC, 3'b101);
    drain();

    // Reset mid-stall drops both held entries.
    a_out_ready = 0;
    send(0, 32'h123452B7, 64'h600, 64'h12345000, 64'h12345600, 3'b100);
    send(0, 32'h0020A423, 64'h604, 64'h8,        64'h60C,      3'b010);
    reset_n = 1'b0;
    @(posedge clk); #1;
    q32.delete();
    chk("midrst_valid", 64'(a_out_valid), 0);
    chk("midrst_in_ready", 64'(a_in_ready), 0);
    reset_n = 1'b1;
    a_out_ready = 1;
    @(posedge clk); #1;
    chk("midrst_release_ready", 64'(a_in_ready), 1);
    chk("midrst_release_valid", 64'(a_out_valid), 0);

    // XLEN=64 instance.
    send(1, 32'h800002B7, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 3'b100);
    send(1, 32'h0200006F, 64'hFFFFFFFFFFFFFFF0, 64'h20, 64'h10, 3'b101);
    send(1, 32'hFFF00093, 64'h8, 64'hFFFFFFFFFFFFFFFF, 64'h7, 3'b001);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
